mem_system_banked: RTL and testbench
====================================

Name: mem_system_banked

Overview:
- Parametrised, byte-banked, word-addressed memory system; next-generation replacement for the single-cycle 4-bank test memory.
- Adds per-byte write enables, a valid/ready request handshake and a configurable fixed read latency.
- Adds out-of-range error reporting and a post-reset zero-initialisation sequencer.
- Sits between the CPU/DMA memory ports and behavioural RAM in simulation and FPGA builds.

Parameters:
DATA_W, 32, word width in bits; multiple of 8; NUM_BANKS = DATA_W/8 byte banks (derived, not overridable)
ADDR_W, 32, byte-address width
DEPTH, 1024, words per bank; power of 2
READ_LATENCY, 2, cycles from request acceptance edge to response; 1..8
INIT_ZERO, 1, 1 = clear all words after reset before accepting requests; 0 = ready immediately, contents undefined

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept request this cycle
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address; bits [1:0] ignored (word aligned)
req_wdata  in  DATA_W  write data; bank i takes bits [8i+7:8i]
req_be  in  NUM_BANKS  byte enables, write only
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DATA_W  read data; 0 for writes and errors
resp_err  out  1  address out of range, qualified by resp_valid
init_done  out  1  initialisation complete

Behaviour:
- Reset: while rst=1 at an edge, all of the following are forced:
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - Response pipeline flushed; in-flight requests dropped, with no response.
  - init_done=0; FSM enters INIT (INIT_ZERO=1) or READY (INIT_ZERO=0).
  - Memory contents are not reset.
- FSM INIT:
  - Counter word index 0..DEPTH-1; writes zero to all banks at that index, one word per cycle.
  - After writing DEPTH-1, transitions to READY.
  - init_done and req_ready rise the cycle after the last clear write: exactly DEPTH cycles after rst deasserts.
- FSM READY:
  - req_ready=1 constantly; no backpressure.
  - Stays in READY until rst.
- Acceptance: a request is accepted on an edge where req_valid & req_ready; at most one request per cycle.
- Word index = req_addr[log2(DEPTH)+1:2]. Out of range if any req_addr bit above log2(DEPTH)+1 is set.
- Write, in range: on the acceptance edge, bank i is updated iff req_be[i]. req_be=0 is a legal no-op.
- Read, in range: the word is sampled on the acceptance edge. A read accepted in the cycle after a write to the same word returns the new data (write-first ordering across cycles).
- Response timing and content:
  - Every accepted request (read, write, error) produces exactly one resp_valid pulse READ_LATENCY cycles after its acceptance edge.
  - Responses are in order; back-to-back requests give back-to-back pulses.
  - Read: resp_rdata = word, resp_err=0.
  - Write: resp_rdata=0, resp_err=0.
  - Out-of-range: resp_rdata=0, resp_err=1, and memory is unchanged.
- Outputs are registered; resp_rdata and resp_err hold 0 when resp_valid=0.
- req_valid during INIT is ignored (not accepted, no response); the requester must hold it.
- rst asserted mid-INIT restarts the counter at 0. rst asserted mid-pipeline drops the outstanding responses.

Test Plan:
1. Init: INIT_ZERO=1, DEPTH=16; deassert rst, then drive req_valid=1 continuously -> no response and req_ready=0 for 16 cycles, init_done=1 on cycle 16. A read of addr 0x3C then returns 0x00000000.
2. Byte enables: write 0xAABBCCDD be=4'b1111 to 0x10, then 0x11223344 be=4'b0101 -> read 0x10 returns 0xAA22CC44, response 2 cycles after acceptance.
3. Back-to-back: write 0xDEADBEEF to 0x08 in cycle n, read 0x08 in cycle n+1 -> resp_valid in cycles n+2 and n+3; second response has rdata 0xDEADBEEF.
4. Out of range: DEPTH=16, write 0x12345678 to 0x40, then read 0x40 -> both responses have resp_err=1, rdata=0. A read of 0x00 is unchanged.
5. Reset mid-flight: accept a read, assert rst the next cycle -> no resp_valid ever for that read; init restarts and takes DEPTH cycles after rst deasserts.
6. Latency sweep: READ_LATENCY=1 and 4 with 8 consecutive reads -> responses are in order, contiguous and exactly 1 and 4 cycles after acceptance respectively.

Source files
------------

// File: rtl/mem_system_banked.sv
// Byte-banked, word-addressed memory with valid/ready requests, per-byte write enables,
// a fixed-latency in-order response pipeline and a post-reset zero-initialisation sweep.
module mem_system_banked #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter bit          INIT_ZERO    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                init_done
);

  localparam int unsigned NUM_BANKS = DATA_W / 8;
  localparam int unsigned IDX_W     = $clog2(DEPTH);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]       state_q;
  logic [IDX_W-1:0] init_cnt_q;
  logic             ready_q;
  logic             done_q;

  logic             accept;
  logic             oor;
  logic             init_wr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] mem_idx;
  logic [DATA_W-1:0] rd_word;
  logic             unused_addr;

  assign unused_addr = ^req_addr[1:0];
  assign idx         = req_addr[IDX_W+1:2];
  assign oor         = |req_addr[ADDR_W-1:IDX_W+2];
  // ready_q can still be high on the edge where rst is first sampled; never act on that edge
  assign accept      = req_valid & ready_q & ~rst;
  assign init_wr     = (state_q == ST_INIT) & ~rst;
  assign mem_idx     = init_wr ? init_cnt_q : idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT_ZERO ? ST_INIT : ST_READY;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: begin
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [7:0] ram [DEPTH];
    logic       we;

    assign we = init_wr | (accept & req_wr & ~oor & req_be[b]);

    // Contents are deliberately not reset
    always_ff @(posedge clk) begin
      if (we) begin
        ram[mem_idx] <= init_wr ? 8'h00 : req_wdata[8*b +: 8];
      end
    end

    assign rd_word[8*b +: 8] = ram[idx];
  end

  logic [READ_LATENCY-1:0] pv_q;
  logic [READ_LATENCY-1:0] pe_q;
  logic [DATA_W-1:0]       pd_q [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= accept;
      pe_q[0] <= accept & oor;
      pd_q[0] <= (accept & ~req_wr & ~oor) ? rd_word : '0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign req_ready  = ready_q;
  assign init_done  = done_q;
  assign resp_valid = pv_q[READ_LATENCY-1];
  assign resp_err   = pe_q[READ_LATENCY-1];
  assign resp_rdata = pd_q[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_system_banked.sv
// Drives three mem_system_banked instances (latency 1, 2, 4) with shared stimulus and checks
// every cycle against a word-array model with a per-cycle expected-response schedule.
module tb_mem_system_banked;

  localparam int unsigned DEP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic [2:0]       rdy;
  logic [2:0]       done;
  logic [2:0]       rv;
  logic [2:0]       re;
  logic [2:0][31:0] rd;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_system_banked #(
      .DATA_W      (32),
      .ADDR_W      (32),
      .DEPTH       (DEP),
      .READ_LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
      .INIT_ZERO   (1'b1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (rdy[g]),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .resp_valid(rv[g]),
      .resp_rdata(rd[g]),
      .resp_err  (re[g]),
      .init_done (done[g])
    );
  end

  int          checks = 0;
  int          errors = 0;
  int          edge_n = 0;
  int          live   = 0;
  int          lat [3] = '{1, 2, 4};
  logic [31:0] mm [DEP];
  bit          sv [3][16];
  bit          se [3][16];
  logic [31:0] sd [3][16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input int e1);
    int          idx;
    bit          oor;
    logic [31:0] d;
    idx = int'((req_addr >> 2) % DEP);
    oor = (req_addr >> 6) != 0;
    d   = '0;
    if (!oor) begin
      if (req_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (req_be[b]) mm[idx][8*b +: 8] = req_wdata[8*b +: 8];
        end
      end else begin
        d = mm[idx];
      end
    end
    for (int g = 0; g < 3; g++) begin
      sv[g][(e1 + lat[g] - 1) % 16] = 1'b1;
      se[g][(e1 + lat[g] - 1) % 16] = oor;
      sd[g][(e1 + lat[g] - 1) % 16] = d;
    end
  endtask

  task automatic tick();
    int e1;
    int s;
    e1 = edge_n + 1;
    if (rst) begin
      live = 0;
      for (int g = 0; g < 3; g++) begin
        for (int k = 0; k < 16; k++) begin
          sv[g][k] = 1'b0;
          se[g][k] = 1'b0;
          sd[g][k] = '0;
        end
      end
    end else begin
      if (live >= int'(DEP) && req_valid) model_accept(e1);
      live++;
      // The clear sweep has just covered every word
      if (live == int'(DEP)) begin
        for (int i = 0; i < int'(DEP); i++) mm[i] = '0;
      end
    end
    @(posedge clk);
    edge_n = e1;
    #1;
    s = e1 % 16;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("req_ready[L%0d] e%0d", lat[g], e1), {31'b0, rdy[g]},
            {31'b0, live >= int'(DEP)});
      check($sformatf("init_done[L%0d] e%0d", lat[g], e1), {31'b0, done[g]},
            {31'b0, live >= int'(DEP)});
      check($sformatf("resp_valid[L%0d] e%0d", lat[g], e1), {31'b0, rv[g]}, {31'b0, sv[g][s]});
      check($sformatf("resp_err[L%0d] e%0d", lat[g], e1), {31'b0, re[g]}, {31'b0, se[g][s]});
      check($sformatf("resp_rdata[L%0d] e%0d", lat[g], e1), rd[g], sd[g][s]);
      sv[g][s] = 1'b0;
      se[g][s] = 1'b0;
      sd[g][s] = '0;
    end
  endtask

  task automatic req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] be);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = data;
    req_be    = be;
    tick();
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    for (int i = 0; i < DEP; i++) mm[i] = 'x;
    for (int i = 0; i < 3; i++) tick();

    // Init: a held read is ignored for DEP cycles, then accepted and returns zero
    rst       = 1'b0;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 32'h3C;
    for (int i = 0; i < DEP + 1; i++) tick();
    idle(5);

    // Byte enables
    req(1'b1, 32'h10, 32'hAABBCCDD, 4'b1111);
    req(1'b1, 32'h10, 32'h11223344, 4'b0101);
    req(1'b0, 32'h10, 32'h0, 4'b0000);
    req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    req(1'b0, 32'h10, 32'h0, 4'b0000);
    idle(5);

    // Write then read the same word on the next cycle
    req(1'b1, 32'h08, 32'hDEADBEEF, 4'b1111);
    req(1'b0, 32'h08, 32'h0, 4'b0000);
    idle(5);

    // Out of range, then confirm word 0 untouched
    req(1'b1, 32'h40, 32'h12345678, 4'b1111);
    req(1'b0, 32'h40, 32'h0, 4'b0000);
    req(1'b0, 32'h00, 32'h0, 4'b0000);
    req(1'b0, 32'h8000_0000, 32'h0, 4'b0000);
    idle(5);

    // Reset with a read in flight
    req(1'b0, 32'h10, 32'h0, 4'b0000);
    req_valid = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle(DEP + 4);

    // Eight consecutive reads after some writes
    for (int i = 0; i < 8; i++) req(1'b1, 32'(i * 4), $urandom, 4'b1111);
    for (int i = 0; i < 8; i++) req(1'b0, 32'(i * 4), 32'h0, 4'b0000);
    idle(6);

    // Randomised traffic with one reset in the middle
    for (int i = 0; i < 300; i++) begin
      int r;
      if (i == 150) begin
        req_valid = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
      end
      r         = int'($urandom_range(0, 9));
      req_valid = ($urandom_range(0, 3) != 0);
      req_wr    = $urandom_range(0, 1) == 1;
      req_wdata = $urandom;
      req_be    = 4'($urandom_range(0, 15));
      if (r == 0) req_addr = $urandom;
      else if (r == 1) req_addr = 32'h40 + 32'($urandom_range(0, 15));
      else req_addr = 32'($urandom_range(0, 63));
      tick();
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
